// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetches variable-length instructions (opcode + 0..2 operands)
//            from byte-wide program memory and owns the program counter.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int                     ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic [7:0]            opcode,
    output logic [7:0]            operando1,
    output logic [7:0]            operando2,
    output logic                  IR_load,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_FETCH_OP = 3'd1;
    localparam logic [2:0] c_FETCH_A1 = 3'd2;
    localparam logic [2:0] c_FETCH_A2 = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = 1;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [7:0]            r_opcode;
    logic [7:0]            r_operando1;
    logic [7:0]            r_operando2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_pc        <= RESET_PC;
            r_opcode    <= 8'h00;
            r_operando1 <= 8'h00;
            r_operando2 <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // A jump request wins over a simultaneous fetch request
                    if (pc_load) begin
                        r_pc <= pc_load_value;
                    end else if (fetch_req) begin
                        r_state <= c_FETCH_OP;
                    end
                end
                c_FETCH_OP: begin
                    if (mem_ready) begin
                        r_opcode    <= mem_rdata;
                        r_operando1 <= 8'h00;
                        r_operando2 <= 8'h00;
                        r_pc        <= r_pc + c_PC_STEP;
                        r_state     <= (mem_rdata[7:6] == 2'b00) ? c_DONE : c_FETCH_A1;
                    end
                end
                c_FETCH_A1: begin
                    if (mem_ready) begin
                        r_operando1 <= mem_rdata;
                        r_pc        <= r_pc + c_PC_STEP;
                        // opcode[7] set means a 3-byte instruction
                        r_state     <= r_opcode[7] ? c_FETCH_A2 : c_DONE;
                    end
                end
                c_FETCH_A2: begin
                    if (mem_ready) begin
                        r_operando2 <= mem_rdata;
                        r_pc        <= r_pc + c_PC_STEP;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign mem_rd    = (r_state == c_FETCH_OP) || (r_state == c_FETCH_A1) ||
                       (r_state == c_FETCH_A2);
    assign mem_addr  = r_pc;
    assign IR_load   = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign pc        = r_pc;
    assign opcode    = r_opcode;
    assign operando1 = r_operando1;
    assign operando2 = r_operando2;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed self-checking bench for instruction_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fetch_req = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_value = 8'h00;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] opcode;
    logic [7:0] operando1;
    logic [7:0] operando2;
    logic       IR_load;
    logic [7:0] pc;
    logic       busy;

    logic [7:0] mem [256];
    int         wait_n = 0;
    int         wcnt   = 0;
    int         n_checks = 0;
    int         n_pass   = 0;

    instruction_fetch #(
        .ADDR_WIDTH (8),
        .RESET_PC   (8'h00)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .opcode        (opcode),
        .operando1     (operando1),
        .operando2     (operando2),
        .IR_load       (IR_load),
        .pc            (pc),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Program memory: each read is held off for wait_n cycles
    assign mem_rdata = mem[mem_addr];
    assign mem_ready = (wcnt >= wait_n);

    always @(posedge clk) begin
        if (mem_rd && mem_ready) wcnt <= 0;
        else if (mem_rd)         wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_fetch(input logic [7:0] e_op, input logic [7:0] e_a1,
                             input logic [7:0] e_a2, input int e_lat,
                             input logic [7:0] e_pc, input int nbytes, input bit jam);
        int         cnt;
        bit         seen;
        logic [7:0] ea;
        logic [7:0] pc_end;
        ea     = e_pc;
        pc_end = e_pc + 8'(nbytes);
        cnt    = 0;
        seen   = 1'b0;
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        #1 fetch_req = 1'b0;
        if (jam) begin
            pc_load       = 1'b1;
            pc_load_value = 8'h10;
        end
        while (!seen && cnt < 40) begin
            @(negedge clk);
            if (mem_rd && !mem_ready) chk("wait_addr", {24'b0, mem_addr}, {24'b0, ea});
            if (mem_rd && mem_ready) ea = ea + 8'd1;
            if (IR_load) begin
                seen    = 1'b1;
                pc_load = 1'b0;
                chk("opcode",    {24'b0, opcode},    {24'b0, e_op});
                chk("operando1", {24'b0, operando1}, {24'b0, e_a1});
                chk("operando2", {24'b0, operando2}, {24'b0, e_a2});
                chk("pc_after",  {24'b0, pc},        {24'b0, pc_end});
            end
            @(posedge clk);
            cnt++;
        end
        pc_load = 1'b0;
        if (!seen) chk("irload_timeout", {31'b0, seen}, 32'd1);
        else       chk("latency", cnt, e_lat);
        @(negedge clk);
        chk("strobe_one_cycle", {31'b0, IR_load}, 32'd0);
        chk("idle_after_done",  {31'b0, busy},    32'd0);
    endtask

    task automatic load_pc(input logic [7:0] v, input logic fr);
        @(negedge clk);
        pc_load       = 1'b1;
        pc_load_value = v;
        fetch_req     = fr;
        @(posedge clk);
        #1;
        pc_load   = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("pc_load", {24'b0, pc}, {24'b0, v});
        chk("pc_load_no_fetch", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int ir_seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h05; mem[1] = 8'h47; mem[2] = 8'hAA;
        mem[3] = 8'h8C; mem[4] = 8'h12; mem[5] = 8'h34;
        mem[6] = 8'h80; mem[7] = 8'h11; mem[8] = 8'h22;
        mem[8'h40] = 8'h41; mem[8'h41] = 8'h55;
        mem[8'hFF] = 8'h40;
        mem[8'h20] = 8'hC0; mem[8'h21] = 8'h01; mem[8'h22] = 8'h02;

        // Asynchronous reset before the first clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_pc",      {24'b0, pc},        32'h00);
        chk("rst_opcode",  {24'b0, opcode},    32'h00);
        chk("rst_op1",     {24'b0, operando1}, 32'h00);
        chk("rst_op2",     {24'b0, operando2}, 32'h00);
        chk("rst_irload",  {31'b0, IR_load},   32'd0);
        chk("rst_mem_rd",  {31'b0, mem_rd},    32'd0);
        chk("rst_busy",    {31'b0, busy},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_busy",   {31'b0, busy},   32'd0);
        chk("idle_mem_rd", {31'b0, mem_rd}, 32'd0);

        // Three instruction lengths, memory always ready
        run_fetch(8'h05, 8'h00, 8'h00, 2, 8'h00, 1, 1'b0);
        run_fetch(8'h47, 8'hAA, 8'h00, 3, 8'h01, 2, 1'b0);
        run_fetch(8'h8C, 8'h12, 8'h34, 4, 8'h03, 3, 1'b0);

        // Two wait cycles before every byte
        wait_n = 2;
        run_fetch(8'h80, 8'h11, 8'h22, 10, 8'h06, 3, 1'b0);
        wait_n = 0;

        // Jump priority over a simultaneous fetch request
        load_pc(8'h40, 1'b1);

        // pc_load held through the whole fetch, including FETCH_A1
        run_fetch(8'h41, 8'h55, 8'h00, 3, 8'h40, 2, 1'b1);

        // Operand fetch wraps from 0xFF to 0x00
        mem[0] = 8'h99;
        load_pc(8'hFF, 1'b0);
        run_fetch(8'h40, 8'h99, 8'h00, 3, 8'hFF, 2, 1'b0);

        // Reset while in FETCH_A2
        load_pc(8'h20, 1'b0);
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        #1 fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a2_addr", {24'b0, mem_addr}, 32'h22);
        #1 rst = 1'b1;
        #1;
        chk("midrst_pc",     {24'b0, pc},      32'h00);
        chk("midrst_busy",   {31'b0, busy},    32'd0);
        chk("midrst_mem_rd", {31'b0, mem_rd},  32'd0);
        chk("midrst_opcode", {24'b0, opcode},  32'h00);
        #2 rst = 1'b0;
        ir_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (IR_load) ir_seen++;
        end
        chk("midrst_no_irload", ir_seen, 0);
        run_fetch(8'h99, 8'h47, 8'hAA, 4, 8'h00, 3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
